// File: rtl/fft8_frame_sequencer.sv
// fft8_frame_sequencer
// Frame-level controller for an 8-point parallel FFT datapath.
// - Collects 8 complex samples from a valid/ready stream into a frame buffer.
// - Holds the frame on the datapath inputs for PIPE_LAT cycles.
// - Captures the 8 results and streams them out in natural bin order.
// Optional build macro FFT_BITREV_EN: when defined, input samples are written
// to bit-reversed slots, so natural-order input lands in decimation-in-time
// order. When undefined, upstream must supply bit-reversed order itself.
module fft8_frame_sequencer #(
   parameter int WIDTH    = 16,
   parameter int PIPE_LAT = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_re,
   input  logic [WIDTH-1:0]   in_im,
   input  logic               in_last,
   output logic [8*WIDTH-1:0] dp_re_o,
   output logic [8*WIDTH-1:0] dp_im_o,
   input  logic [8*WIDTH-1:0] dp_re_i,
   input  logic [8*WIDTH-1:0] dp_im_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_re,
   output logic [WIDTH-1:0]   out_im,
   output logic [2:0]         out_idx,
   output logic               out_last,
   output logic               busy,
   output logic               frame_err
);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_UNLOAD = 2'd2
   } state_t;

   // Frame buffer slot for the wr_cnt-th accepted sample.
   function automatic logic [2:0] wr_addr(input logic [2:0] cnt);
`ifdef FFT_BITREV_EN
      return {cnt[0], cnt[1], cnt[2]};
`else
      return cnt;
`endif
   endfunction

   state_t           state_q, state_d;
   logic [2:0]       wr_cnt_q, wr_cnt_d;
   logic [2:0]       rd_cnt_q, rd_cnt_d;
   logic [3:0]       lat_cnt_q, lat_cnt_d;
   logic [WIDTH-1:0] in_re_q  [8];
   logic [WIDTH-1:0] in_re_d  [8];
   logic [WIDTH-1:0] in_im_q  [8];
   logic [WIDTH-1:0] in_im_d  [8];
   logic [WIDTH-1:0] res_re_q [8];
   logic [WIDTH-1:0] res_re_d [8];
   logic [WIDTH-1:0] res_im_q [8];
   logic [WIDTH-1:0] res_im_d [8];
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_re_q, out_re_d;
   logic [WIDTH-1:0] out_im_q, out_im_d;
   logic [2:0]       out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             busy_q, busy_d;
   logic             frame_err_q, frame_err_d;

   logic             accept_s;
   logic             out_hs_s;
   logic             lat_done_s;
   logic [2:0]       rd_next_s;

   assign in_ready   = (state_q == ST_LOAD);
   assign accept_s   = in_valid & in_ready;
   assign out_hs_s   = out_valid_q & out_ready;
   assign lat_done_s = (lat_cnt_q == 4'(PIPE_LAT));
   assign rd_next_s  = rd_cnt_q + 3'd1;

   assign out_valid = out_valid_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

   // The frame buffer drives the datapath inputs directly.
   for (genvar g = 0; g < 8; g++) begin : g_dp_pack
      assign dp_re_o[g*WIDTH +: WIDTH] = in_re_q[g];
      assign dp_im_o[g*WIDTH +: WIDTH] = in_im_q[g];
   end

   // Next-state logic of the LOAD/RUN/UNLOAD controller.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: begin
            if (accept_s && (wr_cnt_q == 3'd7)) state_d = ST_RUN;
            else                                state_d = ST_LOAD;
         end
         ST_RUN: begin
            if (lat_done_s) state_d = ST_UNLOAD;
            else            state_d = ST_RUN;
         end
         ST_UNLOAD: begin
            if (out_hs_s && (rd_cnt_q == 3'd7)) state_d = ST_LOAD;
            else                                state_d = ST_UNLOAD;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Counters, buffers and registered output fields for the next cycle.
   always_comb begin
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      lat_cnt_d   = lat_cnt_q;
      in_re_d     = in_re_q;
      in_im_d     = in_im_q;
      res_re_d    = res_re_q;
      res_im_d    = res_im_q;
      out_valid_d = out_valid_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      frame_err_d = 1'b0;
      busy_d      = (state_d != ST_LOAD);
      case (state_q)
         ST_LOAD: begin
            if (accept_s) begin
               in_re_d[wr_addr(wr_cnt_q)] = in_re;
               in_im_d[wr_addr(wr_cnt_q)] = in_im;
               if (wr_cnt_q == 3'd7) begin
                  // Frame complete; a missing in_last is flagged but the frame is kept.
                  wr_cnt_d    = 3'd0;
                  lat_cnt_d   = 4'd0;
                  frame_err_d = ~in_last;
               end else if (in_last) begin
                  // Early in_last: drop the partial frame and start over.
                  wr_cnt_d    = 3'd0;
                  frame_err_d = 1'b1;
               end else begin
                  wr_cnt_d = wr_cnt_q + 3'd1;
               end
            end else begin
               wr_cnt_d = wr_cnt_q;
            end
         end
         ST_RUN: begin
            lat_cnt_d = lat_cnt_q + 4'd1;
            if (lat_done_s) begin
               for (int k = 0; k < 8; k++) begin
                  res_re_d[k] = dp_re_i[k*WIDTH +: WIDTH];
                  res_im_d[k] = dp_im_i[k*WIDTH +: WIDTH];
               end
               rd_cnt_d    = 3'd0;
               out_valid_d = 1'b1;
               out_re_d    = dp_re_i[WIDTH-1:0];
               out_im_d    = dp_im_i[WIDTH-1:0];
               out_idx_d   = 3'd0;
               out_last_d  = 1'b0;
            end else begin
               rd_cnt_d = rd_cnt_q;
            end
         end
         ST_UNLOAD: begin
            if (out_hs_s) begin
               if (rd_cnt_q == 3'd7) begin
                  rd_cnt_d    = 3'd0;
                  out_valid_d = 1'b0;
                  out_re_d    = '0;
                  out_im_d    = '0;
                  out_idx_d   = 3'd0;
                  out_last_d  = 1'b0;
               end else begin
                  rd_cnt_d    = rd_next_s;
                  out_re_d    = res_re_q[rd_next_s];
                  out_im_d    = res_im_q[rd_next_s];
                  out_idx_d   = rd_next_s;
                  out_last_d  = (rd_next_s == 3'd7);
               end
            end else begin
               rd_cnt_d = rd_cnt_q;
            end
         end
         default: begin
            wr_cnt_d  = 3'd0;
            rd_cnt_d  = 3'd0;
            lat_cnt_d = 4'd0;
         end
      endcase
   end

   // State and datapath registers; reset clears everything and aborts any frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         wr_cnt_q    <= 3'd0;
         rd_cnt_q    <= 3'd0;
         lat_cnt_q   <= 4'd0;
         for (int k = 0; k < 8; k++) begin
            in_re_q[k]  <= '0;
            in_im_q[k]  <= '0;
            res_re_q[k] <= '0;
            res_im_q[k] <= '0;
         end
         out_valid_q <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         out_idx_q   <= 3'd0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         lat_cnt_q   <= lat_cnt_d;
         in_re_q     <= in_re_d;
         in_im_q     <= in_im_d;
         res_re_q    <= res_re_d;
         res_im_q    <= res_im_d;
         out_valid_q <= out_valid_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
      end
   end

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Directed bench for fft8_frame_sequencer. The attached datapath is modelled
// as a 3-cycle register delay with identity mapping.
module tb_fft8_frame_sequencer;

   localparam int W = 16;

`ifdef FFT_BITREV_EN
   localparam int ORD [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
   localparam int ORD [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_re = '0;
   logic [W-1:0]   in_im = '0;
   logic           in_last = 1'b0;
   logic [8*W-1:0] dp_re_o, dp_im_o, dp_re_i, dp_im_i;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [W-1:0]   out_re, out_im;
   logic [2:0]     out_idx;
   logic           out_last, busy, frame_err;

   logic [8*W-1:0] d_re [3];
   logic [8*W-1:0] d_im [3];

   logic [W-1:0]   s_re [8];
   logic [W-1:0]   s_im [8];
   logic [W-1:0]   e_re [8];
   logic [W-1:0]   e_im [8];

   int total = 0;
   int bad = 0;

   fft8_frame_sequencer #(.WIDTH(W), .PIPE_LAT(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_im(in_im), .in_last(in_last),
      .dp_re_o(dp_re_o), .dp_im_o(dp_im_o),
      .dp_re_i(dp_re_i), .dp_im_i(dp_im_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im),
      .out_idx(out_idx), .out_last(out_last),
      .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 3; i++) begin
         d_re[i] = '0;
         d_im[i] = '0;
      end
   end

   // Datapath model: three register stages, identity mapping.
   always @(posedge clk) begin
      d_re[0] <= dp_re_o;  d_im[0] <= dp_im_o;
      d_re[1] <= d_re[0];  d_im[1] <= d_im[0];
      d_re[2] <= d_re[1];  d_im[2] <= d_im[1];
   end
   assign dp_re_i = d_re[2];
   assign dp_im_i = d_im[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected output bin j is the buffer slot j, which holds sample ORD[j].
   task automatic set_exp();
      for (int j = 0; j < 8; j++) begin
         e_re[j] = s_re[ORD[j]];
         e_im[j] = s_im[ORD[j]];
      end
   endtask

   task automatic fill(input logic [W-1:0] re_base, input logic [W-1:0] re_step,
                       input logic [W-1:0] im_base, input logic [W-1:0] im_step);
      for (int k = 0; k < 8; k++) begin
         s_re[k] = re_base + re_step * W'(k);
         s_im[k] = im_base + im_step * W'(k);
      end
      set_exp();
   endtask

   // Send n samples back to back; in_last on sample last_at (-1 = never).
   task automatic send(input int n, input int last_at);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b1;
         in_re    = s_re[k];
         in_im    = s_im[k];
         in_last  = (k == last_at);
         @(negedge clk);
         check("in_ready_load", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_valid(input int exp_lat);
      int c;
      c = 0;
      while (out_valid !== 1'b1 && c < 50) begin
         if (c == 1) check("busy_run", 32'(busy), 32'd1);
         @(posedge clk); #1;
         c++;
      end
      check("first_valid_lat", 32'(c), 32'(exp_lat));
   endtask

   // Receive nbins results; stall pattern 1,0,0,1 when pat != 0.
   task automatic recv(input int nbins, input int pat);
      int idx, cyc;
      idx = 0;
      cyc = 0;
      while (idx < nbins && cyc < 100) begin
         out_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         check("out_valid", 32'(out_valid), 32'd1);
         check("out_idx", 32'(out_idx), 32'(idx));
         check("out_re", 32'(out_re), 32'(e_re[idx]));
         check("out_im", 32'(out_im), 32'(e_im[idx]));
         check("out_last", 32'(out_last), 32'(idx == 7));
         check("in_ready_unload", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         if (out_ready) idx++;
         cyc++;
      end
      check("recv_count", 32'(idx), 32'(nbins));
      out_ready = 1'b1;
   endtask

   task automatic post_frame();
      check("post_out_valid", 32'(out_valid), 32'd0);
      check("post_in_ready", 32'(in_ready), 32'd1);
      check("post_busy", 32'(busy), 32'd0);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_out_valid", 32'(out_valid), 32'd0);
      check("rel_busy", 32'(busy), 32'd0);
      check("rel_in_ready", 32'(in_ready), 32'd1);
      check("rel_dp_re", 32'(dp_re_o[W-1:0]), 32'd0);
      repeat (6) @(posedge clk);
      #1;
      check("rel_no_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_out_idx", 32'(out_idx), 32'd0);
      check("reset_out_last", 32'(out_last), 32'd0);
      check("reset_out_re", 32'(out_re), 32'd0);
      check("reset_dp_re", 32'(dp_re_o[W-1:0]), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Frame re=k+1, im=-(k+1), always ready
      fill(16'd1, 16'd1, 16'hFFFF, 16'hFFFF);
      send(8, 7);
      check("a_frame_err", 32'(frame_err), 32'd0);
      check("a_busy", 32'(busy), 32'd1);
      check("a_in_ready", 32'(in_ready), 32'd0);
      check("a_dp_slot0", 32'(dp_re_o[0 +: W]), 32'd1);
      check("a_dp_slot1", 32'(dp_re_o[W +: W]), 32'(e_re[1]));
      check("a_dp_slot7_im", 32'(dp_im_o[7*W +: W]), 32'hFFF8);
      wait_valid(4);
      recv(8, 0);
      post_frame();
      check("a_frame_err_end", 32'(frame_err), 32'd0);

      // Same frame with out_ready stall pattern 1,0,0,1
      send(8, 7);
      wait_valid(4);
      recv(8, 1);
      post_frame();

      // Early in_last on 3rd sample, then a full frame of 0x0100
      fill(16'h0AAA, 16'h0011, 16'h0555, 16'h0001);
      send(3, 2);
      check("early_err_pulse", 32'(frame_err), 32'd1);
      check("early_in_ready", 32'(in_ready), 32'd1);
      check("early_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("early_err_clear", 32'(frame_err), 32'd0);
      fill(16'h0100, 16'h0000, 16'h0000, 16'h0000);
      send(8, 7);
      check("b_frame_err", 32'(frame_err), 32'd0);
      wait_valid(4);
      recv(8, 0);
      post_frame();

      // Full frame without in_last
      fill(16'h0203, 16'h0010, 16'h8000, 16'h0101);
      send(8, -1);
      check("nolast_err_pulse", 32'(frame_err), 32'd1);
      @(posedge clk); #1;
      check("nolast_err_clear", 32'(frame_err), 32'd0);
      wait_valid(3);
      recv(8, 0);
      post_frame();

      // Reset during RUN
      fill(16'h1234, 16'h0101, 16'h4321, 16'h0F0F);
      send(8, 7);
      @(posedge clk); #1;
      check("run_busy", 32'(busy), 32'd1);
      reset_pulse();

      // Reset during UNLOAD at bin 4
      send(8, 7);
      wait_valid(4);
      recv(4, 0);
      check("mid_unload_idx", 32'(out_idx), 32'd4);
      reset_pulse();

      // Fresh frame after resets
      fill(16'h7FF0, 16'h0001, 16'h8001, 16'hFFFE);
      send(8, 7);
      wait_valid(4);
      recv(8, 0);
      post_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft8_frame_sequencer.md
Name: fft8_frame_sequencer

Overview:
Frame-level controller for the 8-point parallel FFT datapath (first, second and third butterfly stages, each registered, free-running, no enable).
- Accepts complex samples one per cycle over a valid/ready stream and assembles them into an 8-sample frame buffer.
- Holds the frame stable on the datapath inputs for the pipeline latency, then captures the 8 results.
- Streams the results back out serially with valid/ready and last/index sideband.

Parameters:
WIDTH, 16, bit width of each real/imag sample (stream and datapath buses)
PIPE_LAT, 3, register latency of the attached datapath in cycles (legal 1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input sample valid
in_ready  out  1  input sample accepted when in_valid&in_ready
in_re  in  WIDTH  input sample real, signed
in_im  in  WIDTH  input sample imag, signed
in_last  in  1  marks 8th sample of a frame
dp_re_o  out  8*WIDTH  frame to datapath real; slot k at [k*WIDTH +: WIDTH]
dp_im_o  out  8*WIDTH  frame to datapath imag; same packing
dp_re_i  in  8*WIDTH  datapath result real; same packing
dp_im_i  in  8*WIDTH  datapath result imag; same packing
out_valid  out  1  output sample valid
out_ready  in  1  downstream ready
out_re  out  WIDTH  output sample real
out_im  out  WIDTH  output sample imag
out_idx  out  3  bin index of current output sample (0..7)
out_last  out  1  high with bin 7
busy  out  1  high when not in LOAD
frame_err  out  1  one-cycle pulse on framing error

Behaviour:
- States: LOAD, RUN, UNLOAD. Reset: state=LOAD, wr_cnt=rd_cnt=lat_cnt=0, in_buf and res_buf cleared to 0, out_valid=0, out_last=0, out_idx=0, out_re/out_im=0, frame_err=0, busy=0.
- in_ready = (state==LOAD). dp_re_o/dp_im_o are driven continuously from in_buf.
- LOAD:
  - Each accepted sample is written to in_buf[wr_addr(wr_cnt)], then wr_cnt increments.
  - in_last on an accept with wr_cnt<7: frame_err pulses, the partial frame is discarded, wr_cnt=0, state stays LOAD.
  - Accept with wr_cnt==7: wr_cnt=0, lat_cnt=0, go to RUN. If in_last=0 on this accept, frame_err pulses but the frame is still processed.
- RUN:
  - in_buf is frozen and lat_cnt increments each cycle.
  - On the edge where lat_cnt==PIPE_LAT: res_buf<=dp_re_i/dp_im_i, rd_cnt=0, go to UNLOAD.
  - First out_valid is high PIPE_LAT+1 cycles after the edge that accepted sample 8 (4 cycles at default).
- UNLOAD:
  - out_valid=1, out_re/out_im=res_buf[rd_cnt], out_idx=rd_cnt, out_last=(rd_cnt==7). Outputs are registered/muxed from stable state.
  - All output fields hold constant while out_valid&!out_ready.
  - On handshake rd_cnt increments. The handshake at rd_cnt==7 returns to LOAD, with out_valid low from the next cycle.
- No overlap: no input is accepted during RUN/UNLOAD. Frame period is at least 8+PIPE_LAT+1+8 cycles.
- No arithmetic on data: sample values pass bit-exact between stream and buffers. Counters wrap naturally (3-bit).
- rst_n asserted mid-frame aborts any state immediately; partial input and pending output are lost. No out_valid until a fresh full frame.

Optional Feature:
FFT_BITREV_EN.
- Defined: wr_addr = bit-reverse of wr_cnt (0,4,2,6,1,5,3,7), so natural-order input lands in decimation-in-time slots.
- Undefined: wr_addr = wr_cnt; upstream must supply bit-reversed order.
- Output order is natural in both cases.

Test Plan:
- Bench model: dp is a PIPE_LAT-deep register delay with identity mapping (dp_*_i = dp_*_o delayed 3 cycles).
- Macro off, input re=k+1, im=-(k+1) for k=0..7 with in_last on k=7, out_ready=1: first out_valid exactly 4 cycles after 8th accept; outputs idx0..7 = (1,-1)..(8,-8); out_last only on idx7; frame_err never.
- Macro on, same stimulus: output sequence re = 1,5,3,7,2,6,4,8 at idx 0..7.
- out_ready toggled 1,0,0,1,...: out_re/out_idx/out_last hold steady during stalls, no sample lost or duplicated, in_ready stays 0 until bin 7 accepted.
- in_last on 3rd sample, then a full 8-sample frame of value 0x0100: frame_err single pulse at 3rd accept, first frame discarded, second frame output 8×0x0100.
- Full frame without in_last: frame_err pulses at 8th accept, frame still output normally.
- rst_n pulsed low during RUN and again at UNLOAD idx 4: out_valid=0, busy=0, in_ready=1 after release; next full frame outputs correctly.
